// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   ADDR_W_DEF / INST_W_DEF : default PC and instruction widths
//   state_t                 : fetch FSM states
//   OPC_MSB / OPC_LSB       : opcode field position, for decode
package cpu_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int INST_W_DEF = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_out_stage.sv
// One-entry valid/ready output register for the fetch front end.
//   load    : capture d_inst/d_pc and mark the entry valid
//   accept  : downstream takes the entry this cycle (inst_ready)
//   flush   : drop the entry (redirect); wins over load and accept
//   q_valid / q_inst / q_pc : registered output toward decode
module fetch_out_stage #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              accept,
  input  logic              flush,
  input  logic [INST_W-1:0] d_inst,
  input  logic [ADDR_W-1:0] d_pc,
  output logic              q_valid,
  output logic [INST_W-1:0] q_inst,
  output logic [ADDR_W-1:0] q_pc
);

  logic              valid_d, valid_q;
  logic [INST_W-1:0] inst_d,  inst_q;
  logic [ADDR_W-1:0] pc_d,    pc_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // through the block can infer a latch.
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      inst_d  = d_inst;
      pc_d    = d_pc;
    end else if (valid_q && accept) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the payload registers are reset as well as the valid bit, because
  // inst_out/inst_pc must read 0 out of reset, not just be "don't care".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign q_valid = valid_q;
  assign q_inst  = inst_q;
  assign q_pc    = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the PC and fetch FSM, addresses a
// combinational ROM and hands instructions to decode via valid/ready.
//   start              : pulse, IDLE -> FETCH from address 0
//   halt               : level, suppress new ROM reads
//   redirect_valid/_pc : load PC, flush the output stage (not in IDLE)
//   rom_addr / rom_inst: ROM interface, rom_addr is the PC register
//   inst_valid/ready/out/pc : output handshake toward decode
//   running            : high in FETCH
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter bit WRAP   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              running
);

  localparam logic [ADDR_W-1:0] LAST_PC = {ADDR_W{1'b1}};

  state_t            state_d, state_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              load;
  logic              flush;
  logic              at_end;

  // Redirect is meaningful only once fetch has been started.
  assign flush  = redirect_valid && (state_q != IDLE);
  assign load   = (state_q == FETCH) && !halt && !redirect_valid &&
                  (!inst_valid || inst_ready);
  // With WRAP=0 the last address is terminal: loading it ends the program.
  assign at_end = !WRAP && (pc_q == LAST_PC);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE:  if (start) begin
        state_d = FETCH;
        pc_d    = '0;
      end
      FETCH: begin
        if (flush) begin
          pc_d = redirect_pc;
        end else if (load) begin
          if (at_end) state_d = DONE;
          else        pc_d    = pc_q + ADDR_W'(1);
        end
      end
      DONE:  if (flush) begin
        state_d = FETCH;
        pc_d    = redirect_pc;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_out_stage #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .accept  (inst_ready),
    .flush   (flush),
    .d_inst  (rom_inst),
    .d_pc    (pc_q),
    .q_valid (inst_valid),
    .q_inst  (inst_out),
    .q_pc    (inst_pc)
  );

  assign rom_addr = pc_q;
  assign running  = (state_q == FETCH);

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: one WRAP=1 instance driven through
// start, backpressure, halt, redirect, wrap and async reset, and one WRAP=0
// instance for end-of-program stop and restart by redirect.
module tb_inst_fetch;

  localparam int AW = 4;
  localparam int IW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: opcode 1 for even addresses, F for odd ones.
  function automatic logic [IW-1:0] rom_f(input logic [AW-1:0] a);
    logic [3:0] opc;
    opc = a[0] ? 4'hF : 4'h1;
    return {opc, a, 4'h0, 1'b0, a[3:1]};
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- WRAP=1 instance ----------------
  logic          rst_n = 1'b0, start = 1'b0, halt = 1'b0, inst_ready = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] rom_addr, inst_pc;
  logic [IW-1:0] rom_inst, inst_out;
  logic          inst_valid, running;

  assign rom_inst = rom_f(rom_addr);

  inst_fetch #(.ADDR_W(AW), .INST_W(IW), .WRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_inst(rom_inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .running(running)
  );

  // ---------------- WRAP=0 instance ----------------
  logic          nw_start = 1'b0, nw_halt = 1'b0, nw_ready = 1'b1;
  logic          nw_redir = 1'b0;
  logic [AW-1:0] nw_redir_pc = '0;
  logic [AW-1:0] nw_addr, nw_pc;
  logic [IW-1:0] nw_rom, nw_out;
  logic          nw_valid, nw_running;

  assign nw_rom = rom_f(nw_addr);

  inst_fetch #(.ADDR_W(AW), .INST_W(IW), .WRAP(1'b0)) dut_nw (
    .clk(clk), .rst_n(rst_n), .start(nw_start), .halt(nw_halt),
    .redirect_valid(nw_redir), .redirect_pc(nw_redir_pc),
    .rom_addr(nw_addr), .rom_inst(nw_rom), .inst_valid(nw_valid),
    .inst_ready(nw_ready), .inst_out(nw_out), .inst_pc(nw_pc),
    .running(nw_running)
  );

  // ---------------- scoreboards ----------------
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] nw_q[$];

  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_inst_pc", {28'h0, inst_pc}, 32'hFFFF_FFFF);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        check("sb_pc", {28'h0, inst_pc}, {28'h0, e});
        check("sb_inst", {16'h0, inst_out}, {16'h0, rom_f(e)});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && nw_valid && nw_ready) begin
      if (nw_q.size() == 0) begin
        check("nw_extra_pc", {28'h0, nw_pc}, 32'hFFFF_FFFF);
      end else begin
        logic [AW-1:0] e;
        e = nw_q.pop_front();
        check("nw_sb_pc", {28'h0, nw_pc}, {28'h0, e});
        check("nw_sb_inst", {16'h0, nw_out}, {16'h0, rom_f(e)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit nw, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((nw ? nw_q.size() : exp_q.size()) == 0) break;
      tick();
    end
    check(nw ? "nw_drain" : "drain", nw ? nw_q.size() : exp_q.size(), 0);
  endtask

  initial begin
    // ---- reset state ----
    #12;
    check("rst_valid", {31'h0, inst_valid}, 0);
    check("rst_out", {16'h0, inst_out}, 0);
    check("rst_pc", {28'h0, inst_pc}, 0);
    check("rst_addr", {28'h0, rom_addr}, 0);
    check("rst_running", {31'h0, running}, 0);
    rst_n = 1'b1;
    tick();

    // Redirect in IDLE is ignored.
    redirect_valid = 1'b1; redirect_pc = 4'd7;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("idle_redir_addr", {28'h0, rom_addr}, 0);
    check("idle_valid", {31'h0, inst_valid}, 0);

    // ---- start, streaming with ready=1 ----
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("running", {31'h0, running}, 1);
    check("valid_latency", {31'h0, inst_valid}, 0);
    tick();                       // pc0 loaded
    check("first_valid", {31'h0, inst_valid}, 1);
    tick();                       // pc1
    tick();                       // pc2
    inst_ready = 1'b0;

    // ---- backpressure on pc 2 ----
    for (int i = 0; i < 3; i++) begin
      check("bp_out", {16'h0, inst_out}, 32'h1201);
      check("bp_pc", {28'h0, inst_pc}, 2);
      check("bp_addr", {28'h0, rom_addr}, 3);
      tick();
    end
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd3);
    inst_ready = 1'b1;
    tick();                       // pc2 accepted, pc3 loaded
    halt = 1'b1;
    tick();                       // pc3 accepted, stage empties
    drain(1'b0, 4);

    // ---- halt with stage empty ----
    for (int i = 0; i < 4; i++) begin
      check("halt_valid", {31'h0, inst_valid}, 0);
      check("halt_addr", {28'h0, rom_addr}, 4);
      tick();
    end
    exp_q.push_back(4'd4);
    halt = 1'b0;
    tick();                       // pc4 loaded
    tick();                       // pc4 accepted, pc5 loaded
    inst_ready = 1'b0;
    check("pre_redir_pc", {28'h0, inst_pc}, 5);

    // ---- redirect to 10 while pc5 stalled ----
    redirect_valid = 1'b1; redirect_pc = 4'd10;
    tick();
    redirect_valid = 1'b0;
    check("redir_flush", {31'h0, inst_valid}, 0);
    check("redir_addr", {28'h0, rom_addr}, 10);
    exp_q.push_back(4'd10);
    inst_ready = 1'b1;
    tick();
    check("redir_out", {16'h0, inst_out}, 32'h1A05);
    check("redir_pc", {28'h0, inst_pc}, 10);

    // ---- wrap 11..15,0,1 ----
    for (int p = 11; p <= 17; p++) exp_q.push_back(AW'(p));
    repeat (7) tick();
    halt = 1'b1;
    tick();
    drain(1'b0, 4);
    check("wrap_addr", {28'h0, rom_addr}, 2);

    // ---- async reset mid-stream ----
    inst_ready = 1'b0;
    halt = 1'b0;
    tick();                       // pc2 loaded, held
    check("pre_rst_valid", {31'h0, inst_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", {31'h0, inst_valid}, 0);
    check("async_addr", {28'h0, rom_addr}, 0);
    check("async_running", {31'h0, running}, 0);
    #3 rst_n = 1'b1;
    inst_ready = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_idle", {30'h0, running, inst_valid}, 0);
      check("post_rst_addr", {28'h0, rom_addr}, 0);
    end

    // ---- WRAP=0: run to end, stop, restart via redirect ----
    for (int p = 0; p < 16; p++) nw_q.push_back(AW'(p));
    nw_start = 1'b1;
    tick();
    nw_start = 1'b0;
    repeat (18) tick();
    check("nw_drain_first", nw_q.size(), 0);
    check("nw_done_running", {31'h0, nw_running}, 0);
    check("nw_done_valid", {31'h0, nw_valid}, 0);
    check("nw_done_addr", {28'h0, nw_addr}, 15);
    repeat (2) tick();
    check("nw_stays_done", {31'h0, nw_valid}, 0);
    for (int p = 0; p < 16; p++) nw_q.push_back(AW'(p));
    nw_redir = 1'b1; nw_redir_pc = 4'd0;
    tick();
    nw_redir = 1'b0;
    check("nw_restart", {31'h0, nw_running}, 1);
    drain(1'b1, 40);
    repeat (3) tick();
    check("nw_done2_running", {31'h0, nw_running}, 0);
    check("nw_done2_valid", {31'h0, nw_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
